// File: rtl/switch_debouncer.sv
// Per-channel switch conditioner: two-flop synchroniser, stability-counter debounce,
// registered rise/fall pulses, press-toggle state and a registered XOR of all levels.
module switch_debouncer #(
    parameter int N_SW          = 2,
    parameter int STABLE_CYCLES = 16000,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_level,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sw_toggle,
    output logic            led
);

    localparam int              CNT_W     = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam bit              LED_RESET = (N_SW % 2 == 1) ? RESET_LEVEL : 1'b0;

    logic [N_SW-1:0] level_next_vec;
    logic            led_reg;

    generate
        for (genvar gi = 0; gi < N_SW; gi++) begin : g_ch
            logic             sync1_reg;
            logic             sync2_reg;
            logic             level_reg;
            logic             level_next;
            logic             rise_reg;
            logic             fall_reg;
            logic             toggle_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    sync1_reg <= RESET_LEVEL;
                    sync2_reg <= RESET_LEVEL;
                end else begin
                    sync1_reg <= sw_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Any cycle agreeing with the current level restarts the stability count.
            always_comb begin
                cnt_next   = cnt_reg;
                level_next = level_reg;
                if (sync2_reg == level_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_MAX) begin
                    level_next = sync2_reg;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    cnt_reg    <= '0;
                    level_reg  <= RESET_LEVEL;
                    rise_reg   <= 1'b0;
                    fall_reg   <= 1'b0;
                    toggle_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    level_reg  <= level_next;
                    rise_reg   <= level_next & ~level_reg;
                    fall_reg   <= ~level_next & level_reg;
                    toggle_reg <= toggle_reg ^ (level_next & ~level_reg);
                end
            end

            assign level_next_vec[gi] = level_next;
            assign sw_level[gi]       = level_reg;
            assign sw_rise[gi]        = rise_reg;
            assign sw_fall[gi]        = fall_reg;
            assign sw_toggle[gi]      = toggle_reg;
        end
    endgenerate

    // Built from next-state levels so led moves on the same edge as sw_level.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            led_reg <= LED_RESET;
        end else begin
            led_reg <= ^level_next_vec;
        end
    end

    assign led = led_reg;

endmodule
